// File: rtl/cdc_handshake_tx_if.sv
// Bundle of the source-side and destination-side signals of the 4-phase
// CDC transmitter. The master modport is the transmitter's view; the slave
// modport is the view of whatever drives the words and the acknowledge.
`timescale 1ns/1ps

interface cdc_handshake_tx_if #(
  parameter int S = 12
);
  logic         in_valid;
  logic [S-1:0] in_data;
  logic         in_ready;
  logic         req_out;
  logic [S-1:0] data_out;
  logic         ack_in;
  logic         done;
  logic         clr_err;
  logic         err_timeout;

  modport master (
    input  in_valid,
    input  in_data,
    input  ack_in,
    input  clr_err,
    output in_ready,
    output req_out,
    output data_out,
    output done,
    output err_timeout
  );

  modport slave (
    output in_valid,
    output in_data,
    output ack_in,
    output clr_err,
    input  in_ready,
    input  req_out,
    input  data_out,
    input  done,
    input  err_timeout
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Transmit side of a 4-phase req/ack clock-domain crossing. A word taken
// from the source is held on data_out while req_out is raised; the
// destination's acknowledge is synchronized before the FSM looks at it.
// A saturating wait counter flags (but never aborts) a slow destination.
`timescale 1ns/1ps

module cdc_handshake_tx #(
  parameter int S       = 12,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  cdc_handshake_tx_if.master bus
);

  localparam int                CNT_W  = 16;
  localparam logic [CNT_W-1:0]  TO_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_HI  = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               ack_s1;
  logic               ack_s2;
  logic               req;
  logic               req_nxt;
  logic               done_r;
  logic               done_nxt;
  logic               capture;
  logic [S-1:0]       data_hold;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               err_set;
  logic               err_flag;
  logic               ready;

  // Saturating increment: the wait counter stops at the timeout limit and
  // can therefore never wrap back to a small value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= TO_LIM) begin
      sat_inc = TO_LIM;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Ready only when idle and the destination has released its acknowledge,
  // so a stale ack from an earlier transfer can never start a new one.
  assign ready = (state == IDLE) && !ack_s2;

  // Two-flop synchronizer on the asynchronous acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= bus.ack_in;
      ack_s2 <= ack_s1;
    end
  end

  // Handshake sequencing: accept -> raise req -> ack seen -> drop req ->
  // ack released -> done.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid && ready) begin
          state_nxt = REQ_HI;
          req_nxt   = 1'b1;
          capture   = 1'b1;
        end
      end
      REQ_HI: begin
        if (ack_s2) begin
          state_nxt = WAIT_LO;
          req_nxt   = 1'b0;
        end
      end
      WAIT_LO: begin
        if (!ack_s2) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Wait-counter next value: cleared on entry to either waiting state,
  // incremented while staying there; the flag fires on reaching the limit.
  always_comb begin
    cnt_nxt = '0;
    err_set = 1'b0;
    if (state_nxt != IDLE) begin
      if (state_nxt != state) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = sat_inc(wait_cnt);
        err_set = (wait_cnt != TO_LIM) && (cnt_nxt == TO_LIM);
      end
    end
  end

  // FSM state, request and completion pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      req    <= req_nxt;
      done_r <= done_nxt;
    end
  end

  // Held word: only loaded on an accept, so it stays stable for the whole
  // transfer and until the next word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_hold <= '0;
    end else if (capture) begin
      data_hold <= bus.in_data;
    end
  end

  // Wait counter and sticky timeout flag; a set on the same edge as a clear
  // wins so a timeout is never silently lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      wait_cnt <= cnt_nxt;
      if (err_set) begin
        err_flag <= 1'b1;
      end else if (bus.clr_err) begin
        err_flag <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = ready;
  assign bus.req_out     = req;
  assign bus.data_out    = data_hold;
  assign bus.done        = done_r;
  assign bus.err_timeout = err_flag;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Testbench for cdc_handshake_tx: a destination model answers requests,
// a monitor compares each held word against a queue of accepted words.
`timescale 1ns/1ps

module tb_cdc_handshake_tx;

  localparam int S  = 12;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;

  logic [S-1:0] exp_q[$];

  logic auto_ack;
  logic ack_auto;
  logic ack_man;
  bit   rand_dly;
  int   dly_hi;
  int   dly_lo;

  cdc_handshake_tx_if #(.S(S)) bus ();

  cdc_handshake_tx #(.S(S), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.ack_in = auto_ack ? ack_auto : ack_man;

  // Destination model: raise ack dly_hi cycles after req is seen high,
  // drop it dly_lo cycles after req is seen low.
  initial begin
    int d;
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && !ack_auto && bus.req_out) begin
        d = rand_dly ? int'($urandom_range(0, 20)) : dly_hi;
        repeat (d) @(negedge clk);
        ack_auto = 1'b1;
      end else if (auto_ack && ack_auto && !bus.req_out) begin
        d = rand_dly ? int'($urandom_range(0, 20)) : dly_lo;
        repeat (d) @(negedge clk);
        ack_auto = 1'b0;
      end
    end
  end

  // Monitor: held word at each req rise, stability while req high,
  // one done per accepted word.
  initial begin
    logic         prev_req;
    logic         prev_done;
    logic [S-1:0] held;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (bus.req_out === 1'b1 && !prev_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_req_rise: data_out=%h with no accepted word pending", bus.data_out);
        end else if (bus.data_out !== exp_q[0]) begin
          failures++;
          $display("FAIL mon_req_rise: data_out=%h expected %h", bus.data_out, exp_q[0]);
        end
        held = bus.data_out;
      end else if (bus.req_out === 1'b1 && prev_req) begin
        checks++;
        if (bus.data_out !== held) begin
          failures++;
          $display("FAIL mon_stable: data_out=%h expected held %h", bus.data_out, held);
        end
      end
      if (bus.done === 1'b1) begin
        checks++;
        if (prev_done) begin
          failures++;
          $display("FAIL mon_done_width: done=1 on consecutive cycles, expected 1-cycle pulse");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_done_extra: done=1 with no accepted word pending");
        end else begin
          void'(exp_q.pop_front());
          done_cnt++;
        end
      end
      prev_req  = (bus.req_out === 1'b1);
      prev_done = (bus.done === 1'b1);
    end
  end

  // Offer a word and wait (bounded) for it to be taken; on accept the
  // word is queued for the monitor and the task returns just after the
  // accepting edge.
  task automatic send_word(input logic [S-1:0] w, input bit hold,
                           output bit ok, output logic done_seen);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok        = (bus.in_ready === 1'b1);
    done_seen = bus.done;
    if (ok) begin
      exp_q.push_back(w);
      acc_cnt++;
      @(posedge clk);
      #1;
    end
    if (!hold || !ok) bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_out !== 1'b0) begin failures++; $display("FAIL reset_req_out: got %b expected 0", bus.req_out); end
    checks++;
    if (bus.data_out !== '0) begin failures++; $display("FAIL reset_data_out: got %h expected 000", bus.data_out); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.err_timeout); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    bit   ok;
    logic d;
    int   n_done;
    int   fall_at;
    int   done_at;
    auto_ack = 1'b1; rand_dly = 1'b0; dly_hi = 2; dly_lo = 2;
    send_word(12'hA5C, 1'b0, ok, d);
    checks++;
    if (!ok || bus.req_out !== 1'b1) begin
      failures++;
      $display("FAIL basic_accept: ok=%0b req_out=%b expected 1/1", ok, bus.req_out);
    end
    n_done = 0; fall_at = -1; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_out !== 1'b1 && fall_at < 0) fall_at = i;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = i;
      end
    end
    checks++;
    if (n_done != 1) begin failures++; $display("FAIL basic_done_count: got %0d expected 1", n_done); end
    checks++;
    if (fall_at != 5) begin failures++; $display("FAIL basic_req_fall: at cycle %0d expected 5", fall_at); end
    checks++;
    if (done_at != 10) begin failures++; $display("FAIL basic_done_time: at cycle %0d expected 10", done_at); end
    checks++;
    if (bus.data_out !== 12'hA5C) begin failures++; $display("FAIL basic_data: got %h expected a5c", bus.data_out); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    bit   ok1, ok2;
    logic d1, d2;
    int   base;
    base = done_cnt;
    auto_ack = 1'b1; rand_dly = 1'b0; dly_hi = 2; dly_lo = 2;
    send_word(12'h001, 1'b1, ok1, d1);
    send_word(12'h002, 1'b1, ok2, d2);
    bus.in_valid = 1'b0;
    checks++;
    if (!(ok1 && ok2)) begin failures++; $display("FAIL b2b_accept: ok1=%0b ok2=%0b expected 1/1", ok1, ok2); end
    checks++;
    if (d2 !== 1'b1) begin failures++; $display("FAIL b2b_second_after_done: done=%b at second accept expected 1", d2); end
    for (int i = 0; i < 100 && (done_cnt - base) < 2; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_cnt - base != 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - base); end
    checks++;
    if (bus.data_out !== 12'h002) begin failures++; $display("FAIL b2b_data: got %h expected 002", bus.data_out); end
  endtask

  task automatic test_stale_ack();
    int bad;
    auto_ack = 1'b0; ack_man = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.in_data  = 12'h3C3;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.req_out !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stale_hold: %0d cycles with in_ready/req_out high, expected 0", bad); end
    @(negedge clk);
    ack_man = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stale_edge1: in_ready=%b expected 0", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stale_edge2: in_ready=%b expected 1", bus.in_ready); end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_out !== 1'b0) begin failures++; $display("FAIL stale_no_accept: req_out=%b expected 0", bus.req_out); end
  endtask

  task automatic test_timeout();
    bit   ok;
    logic d;
    logic exp_err;
    int   bad;
    bit   seen;
    auto_ack = 1'b0; ack_man = 1'b0;
    send_word(12'h7E1, 1'b0, ok, d);
    bus.clr_err = 1'b1;
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_accept: ok=%0b expected 1", ok); end
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk);
      #1;
      exp_err = (k == TO);
      checks++;
      if (bus.err_timeout !== exp_err) begin
        failures++;
        $display("FAIL timeout_flag_k%0d: err_timeout=%b expected %b", k, bus.err_timeout, exp_err);
      end
      checks++;
      if (bus.req_out !== 1'b1) begin failures++; $display("FAIL timeout_req_k%0d: req_out=%b expected 1", k, bus.req_out); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: err_timeout=%b expected 0", bus.err_timeout); end
    bus.clr_err = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.err_timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL timeout_saturate: err_timeout set again on %0d cycles expected 0", bad); end
    @(negedge clk);
    ack_man = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_out === 1'b0) seen = 1'b1;
    end
    ack_man = 1'b0;
    checks++;
    if (!seen) begin failures++; $display("FAIL timeout_req_fall: req_out=%b expected 0 after ack", bus.req_out); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL timeout_done: done=%b expected a pulse", bus.done); end
    checks++;
    if (bus.err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_late_err: err_timeout=%b expected 0", bus.err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    logic d;
    bit   seen;
    int   bad;
    auto_ack = 1'b1; rand_dly = 1'b0; dly_hi = 2; dly_lo = 2;
    send_word(12'h5A5, 1'b0, ok, d);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_out === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!(ok && seen)) begin failures++; $display("FAIL rstmid_reach_wait: ok=%0b req_fall=%0b expected 1/1", ok, seen); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_out !== 1'b0 || bus.done !== 1'b0 || bus.err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: req=%b done=%b err=%b expected 0/0/0", bus.req_out, bus.done, bus.err_timeout);
    end
    checks++;
    if (bus.data_out !== '0) begin failures++; $display("FAIL rstmid_data: got %h expected 000", bus.data_out); end
    rst = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rstmid_no_done: done high on %0d cycles expected 0", bad); end
    send_word(12'h0F0, 1'b0, ok, d);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!(ok && seen)) begin failures++; $display("FAIL rstmid_new_xfer: ok=%0b done=%0b expected 1/1", ok, seen); end
    checks++;
    if (bus.data_out !== 12'h0F0) begin failures++; $display("FAIL rstmid_new_data: got %h expected 0f0", bus.data_out); end
  endtask

  task automatic test_random();
    bit           ok;
    bit           hold;
    logic         d;
    logic [S-1:0] w;
    int           nbad;
    int           base_done;
    int           base_acc;
    auto_ack = 1'b1; rand_dly = 1'b1;
    base_done = done_cnt;
    base_acc  = acc_cnt;
    nbad = 0;
    for (int i = 0; i < 1000; i++) begin
      w    = S'($urandom_range(0, 4095));
      hold = ($urandom_range(0, 1) == 1);
      if (bus.in_valid !== 1'b1) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(w, hold, ok, d);
      if (!ok) nbad++;
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (nbad != 0) begin failures++; $display("FAIL rand_accept: %0d words not accepted expected 0", nbad); end
    checks++;
    if (done_cnt - base_done != 1000) begin
      failures++;
      $display("FAIL rand_done_count: got %0d expected 1000", done_cnt - base_done);
    end
    checks++;
    if (acc_cnt - base_acc != done_cnt - base_done) begin
      failures++;
      $display("FAIL rand_done_per_accept: accepts=%0d dones=%0d expected equal", acc_cnt - base_acc, done_cnt - base_done);
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_drain: %0d words pending expected 0", exp_q.size()); end
  endtask

  initial begin
    rst          = 1'b1;
    auto_ack     = 1'b1;
    ack_man      = 1'b0;
    rand_dly     = 1'b0;
    dly_hi       = 2;
    dly_lo       = 2;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clr_err  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stale_ack();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
